// File: rtl/layer2_mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : layer2_mac_pkg
//  Description : Shared widths, FSM encoding and saturation limits for the
//                layer-2 multiply-accumulate scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package layer2_mac_pkg;

    // Operand, product and result widths
    localparam int c_op_w   = 16;
    localparam int c_prod_w = 32;
    localparam int c_res_w  = 32;

    // Scheduler state encoding
    typedef logic [1:0] mac_state_t;
    localparam mac_state_t c_st_idle  = 2'd0;
    localparam mac_state_t c_st_run   = 2'd1;
    localparam mac_state_t c_st_drain = 2'd2;
    localparam mac_state_t c_st_out   = 2'd3;

    // Result saturation limits: [-2^31, 2^31-1]
    localparam logic [c_res_w-1:0] c_sat_max = 32'h7FFF_FFFF;
    localparam logic [c_res_w-1:0] c_sat_min = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/layer2_mac_mul.sv
`default_nettype none
// ============================================================================
//  Module      : layer2_mac_mul
//  Description : Combinational signed 16x16 -> 32 multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer2_mac_mul
    import layer2_mac_pkg::*;
(
    input  logic signed [c_op_w-1:0]   i_a,
    input  logic signed [c_op_w-1:0]   i_b,
    output logic signed [c_prod_w-1:0] o_p
);

    // Both operands signed, so the 32-bit context sign-extends before multiply
    assign o_p = i_a * i_b;

endmodule
`default_nettype wire

// File: rtl/layer2_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : layer2_mac_sched
//  Description : Dot-product job scheduler. Streams N operand pairs out of two
//                1-cycle-latency buffers, multiplies, accumulates at full
//                precision and returns a saturated 32-bit result through a
//                valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer2_mac_sched
    import layer2_mac_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int ACC_WIDTH  = 40
)(
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic                    ap_start,
    output logic                    ap_idle,
    input  logic [ADDR_WIDTH:0]     len,
    input  logic [31:0]             bias,
    output logic [ADDR_WIDTH-1:0]   a_addr,
    output logic [ADDR_WIDTH-1:0]   b_addr,
    output logic                    a_ce,
    output logic                    b_ce,
    input  logic [c_op_w-1:0]       a_q,
    input  logic [c_op_w-1:0]       b_q,
    output logic [c_res_w-1:0]      result,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int c_ext_w = ACC_WIDTH - c_res_w;

    // Saturation limits widened to accumulator width
    localparam logic signed [ACC_WIDTH-1:0] c_acc_max = {{c_ext_w{1'b0}}, c_sat_max};
    localparam logic signed [ACC_WIDTH-1:0] c_acc_min = {{c_ext_w{1'b1}}, c_sat_min};

    localparam logic [ADDR_WIDTH:0] c_cnt_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

    mac_state_t                     r_state;
    logic [ADDR_WIDTH:0]            r_len;
    logic [ADDR_WIDTH:0]            r_cnt;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [c_prod_w-1:0]     r_prod;
    logic                           r_v_data;
    logic                           r_v_prod;

    logic                           w_run;
    logic                           w_accept;
    logic                           w_last_issue;
    logic signed [c_prod_w-1:0]     w_prod;
    logic [c_res_w-1:0]             w_sat;

    assign w_run        = (r_state == c_st_run);
    assign w_accept     = (r_state == c_st_idle) && ap_start;
    // Counter is one bit wider than the address so N = 2^ADDR_WIDTH never wraps
    assign w_last_issue = ((r_cnt + c_cnt_one) == r_len);

    layer2_mac_mul u_mul (
        .i_a (a_q),
        .i_b (b_q),
        .o_p (w_prod)
    );

    // Job-control FSM: IDLE -> RUN -> DRAIN -> OUT, or IDLE -> OUT for N=0
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= c_st_idle;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (ap_start) begin
                        r_len   <= len;
                        r_cnt   <= '0;
                        r_state <= (len == '0) ? c_st_out : c_st_run;
                    end
                end
                c_st_run: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    if (w_last_issue) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    // Last product is being added on this edge and nothing else is in flight
                    if (r_v_prod && !r_v_data) begin
                        r_state <= c_st_out;
                    end
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Datapath pipeline: buffer data valid -> product register -> accumulator
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_v_data <= 1'b0;
            r_v_prod <= 1'b0;
            r_prod   <= '0;
        end else begin
            r_v_data <= w_run;
            r_v_prod <= r_v_data;
            if (r_v_data) begin
                r_prod <= w_prod;
            end
        end
    end

    // Accumulator: seeded with the bias on job accept, full precision thereafter
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= {{c_ext_w{bias[31]}}, bias};
        end else if (r_v_prod) begin
            r_acc <= r_acc + {{c_ext_w{r_prod[c_prod_w-1]}}, r_prod};
        end
    end

    // Clamp the accumulator into the signed 32-bit result range
    always_comb begin
        w_sat = r_acc[c_res_w-1:0];
        if (r_acc > c_acc_max) begin
            w_sat = c_sat_max;
        end else if (r_acc < c_acc_min) begin
            w_sat = c_sat_min;
        end
    end

    assign ap_idle   = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_out);
    assign result    = out_valid ? w_sat : '0;
    assign a_ce      = w_run;
    assign b_ce      = w_run;
    assign a_addr    = w_run ? r_cnt[ADDR_WIDTH-1:0] : '0;
    assign b_addr    = w_run ? r_cnt[ADDR_WIDTH-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_layer2_mac_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer2_mac_sched
//  Description : Directed self-checking bench for layer2_mac_sched with
//                behavioural 1-cycle-latency operand buffers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer2_mac_sched;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_idle;
    logic [8:0]  len;
    logic [31:0] bias;
    logic [7:0]  a_addr;
    logic [7:0]  b_addr;
    logic        a_ce;
    logic        b_ce;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem_a [0:255];
    logic [15:0] mem_b [0:255];
    int          issue_cnt [0:255];
    int          base_cnt  [0:255];
    int          ce_cycles  = 0;
    int          pair_skew  = 0;

    layer2_mac_sched #(
        .ADDR_WIDTH (8),
        .ACC_WIDTH  (40)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .ap_start  (ap_start),
        .ap_idle   (ap_idle),
        .len       (len),
        .bias      (bias),
        .a_addr    (a_addr),
        .b_addr    (b_addr),
        .a_ce      (a_ce),
        .b_ce      (b_ce),
        .a_q       (a_q),
        .b_q       (b_q),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 ap_clk = ~ap_clk;

    // Operand buffers with one cycle of read latency, plus issue bookkeeping
    initial begin
        for (int i = 0; i < 256; i++) issue_cnt[i] = 0;
    end

    always @(posedge ap_clk) begin
        if (a_ce) begin
            a_q <= mem_a[a_addr];
            issue_cnt[a_addr] <= issue_cnt[a_addr] + 1;
            ce_cycles <= ce_cycles + 1;
        end
        if (b_ce) b_q <= mem_b[b_addr];
        if ((a_ce !== b_ce) || (a_addr !== b_addr)) pair_skew <= pair_skew + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 256; i++) base_cnt[i] = issue_cnt[i];
    endtask

    task automatic check_issues(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if ((issue_cnt[i] - base_cnt[i]) != ((i < n) ? 1 : 0)) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Starts a job from a negedge and returns at the negedge where out_valid is first seen
    task automatic run_job(input string tag, input int n, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_lat);
        int k;
        ap_start = 1'b1;
        len      = 9'(n);
        bias     = b;
        @(negedge ap_clk);
        ap_start = 1'b0;
        k = 1;
        while (!out_valid && k < 400) begin
            @(negedge ap_clk);
            k++;
        end
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_result"}, result, exp_res);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge ap_clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 1'b0);
        chk({tag, "_idle"}, ap_idle, 1'b1);
    endtask

    initial begin
        int ce_base;
        int hi;
        ap_rst    = 1'b1;
        ap_start  = 1'b0;
        len       = '0;
        bias      = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge ap_clk);

        // Reset state
        chk("rst_idle", ap_idle, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_ce", {a_ce, b_ce}, 2'b00);
        chk("rst_addr", {a_addr, b_addr}, 16'h0000);
        chk("rst_result", result, 32'h0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        // N=4: 10 + 5 + 12 + 21 + 32 = 80, valid 7 cycles after start
        mem_a[0] = 16'd1; mem_a[1] = 16'd2; mem_a[2] = 16'd3; mem_a[3] = 16'd4;
        mem_b[0] = 16'd5; mem_b[1] = 16'd6; mem_b[2] = 16'd7; mem_b[3] = 16'd8;
        snap();
        run_job("n4", 4, 32'd10, 32'd80, 7);
        check_issues("n4_issue", 4);
        handshake("n4");

        // N=0: bias passes straight through, no reads
        ce_base = ce_cycles;
        run_job("n0", 0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 1);
        chk("n0_no_ce", ce_cycles - ce_base, 0);
        handshake("n0");

        // N=256 of 0x7FFF^2: sum far above 2^31-1, saturates positive
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h7FFF;
            mem_b[i] = 16'h7FFF;
        end
        snap();
        run_job("n256", 256, 32'd0, 32'h7FFF_FFFF, 259);
        check_issues("n256_issue", 256);
        handshake("n256");

        // N=2: 2 * (-32768 * 32767) - 1 = -2147418113, exact
        mem_a[0] = 16'h8000; mem_a[1] = 16'h8000;
        mem_b[0] = 16'h7FFF; mem_b[1] = 16'h7FFF;
        run_job("n2", 2, 32'hFFFF_FFFF, 32'h8000_FFFF, 5);
        handshake("n2");

        // Hold in OUT with out_ready low; a start pulse here must be ignored
        mem_a[0] = 16'd2; mem_b[0] = 16'd3;
        run_job("hold", 1, 32'd1, 32'd7, 4);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ap_start = 1'b1;
                len      = 9'd0;
                bias     = 32'd999;
            end
            @(negedge ap_clk);
            ap_start = 1'b0;
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_result", result, 32'd7);
            chk("hold_not_idle", ap_idle, 1'b0);
        end
        handshake("hold");
        // Back-to-back start in the cycle right after the handshake
        run_job("b2b", 0, 32'd42, 32'd42, 1);
        handshake("b2b");

        // Reset in the middle of an N=10 job
        for (int i = 0; i < 10; i++) begin
            mem_a[i] = 16'd1;
            mem_b[i] = 16'd1;
        end
        ap_start = 1'b1;
        len      = 9'd10;
        bias     = 32'd0;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (3) @(negedge ap_clk);
        chk("mid_run_ce", a_ce, 1'b1);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        chk("mrst_idle", ap_idle, 1'b1);
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_ce", {a_ce, b_ce}, 2'b00);
        chk("mrst_addr", {a_addr, b_addr}, 16'h0000);
        chk("mrst_result", result, 32'h0);
        ap_rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (out_valid) hi++;
        end
        chk("mrst_no_result", hi, 0);
        mem_a[0] = 16'd3;
        mem_b[0] = 16'hFFFC;
        run_job("post_rst", 1, 32'd0, 32'hFFFF_FFF4, 4);
        handshake("post_rst");

        chk("pair_lockstep", pair_skew, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
